// File: rtl/wave_ctrl_pkg.sv
// Shared constants for the sine-ROM waveform sequencer: register map, CTRL bits, FSM states.
package wave_ctrl_pkg;
  localparam int unsigned DEFAULT_DIV = 64000;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_STEP_DIV = 2'd1;
  localparam logic [1:0] ADDR_BURST_N  = 2'd2;
  localparam logic [1:0] ADDR_PHASE    = 2'd3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_STOP    = 1;
  localparam int CTRL_MODE    = 2;
  localparam int CTRL_WSEL_LO = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;
endpackage

// File: rtl/wave_step_timer.sv
// Step divider: counts clk cycles per ROM step and ticks on the last one.
// The programmed divider is only picked up on load or at a step boundary.
module wave_step_timer #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             run_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] active_q, active_d;
  logic [DIV_W-1:0] div_eff;

  assign div_eff = (div_i == '0) ? DIV_W'(1) : div_i;
  assign tick_o  = run_i && (cnt_q == active_q - DIV_W'(1));

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load_i) begin
      cnt_d    = '0;
      active_d = div_eff;
    end else if (!run_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      // shadowed divider takes effect only here, so a step in flight keeps its length
      cnt_d    = '0;
      active_d = div_eff;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= DIV_W'(1);
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end
endmodule

// File: rtl/wave_seq_ctrl.sv
// Waveform sequencer: host register file, run/burst FSM and ROM address counter.
// All strobes and status outputs are registered.
module wave_seq_ctrl #(
  parameter int unsigned DEFAULT_DIV = wave_ctrl_pkg::DEFAULT_DIV,
  parameter int          DIV_W       = 32,
  parameter int          BURST_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  output logic [7:0]  rom_addr,
  output logic        step_pulse,
  output logic        sync_pulse,
  output logic [1:0]  wave_sel,
  output logic        busy,
  output logic        done_pulse
);
  import wave_ctrl_pkg::*;

  state_e             state_q;
  logic [DIV_W-1:0]   step_div_q;
  logic [BURST_W-1:0] burst_n_q, periods_q, periods_inc, burst_eff;
  logic [7:0]         phase_q, rom_addr_q, rom_addr_inc;
  logic               mode_q;
  logic [1:0]         wave_sel_q;
  logic               step_q, sync_q, done_q, busy_q;
  logic               wr, start_cmd, stop_cmd, tick;

  assign cmd_ready    = (state_q != ST_ARM);
  assign wr           = cmd_valid && cmd_ready;
  assign start_cmd    = wr && (cmd_addr == ADDR_CTRL) && cmd_data[CTRL_START];
  assign stop_cmd     = wr && (cmd_addr == ADDR_CTRL) && cmd_data[CTRL_STOP];
  assign burst_eff    = (burst_n_q == '0) ? BURST_W'(1) : burst_n_q;
  assign rom_addr_inc = rom_addr_q + 8'd1;
  assign periods_inc  = periods_q + BURST_W'(1);

  wave_step_timer #(.DIV_W(DIV_W)) u_step_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (state_q == ST_ARM),
    .run_i  (state_q == ST_RUN),
    .div_i  (step_div_q),
    .tick_o (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      step_div_q <= DIV_W'(DEFAULT_DIV);
      burst_n_q  <= BURST_W'(1);
      phase_q    <= '0;
      mode_q     <= 1'b0;
      wave_sel_q <= '0;
      rom_addr_q <= '0;
      periods_q  <= '0;
      step_q     <= 1'b0;
      sync_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      step_q <= 1'b0;
      sync_q <= 1'b0;
      done_q <= 1'b0;

      if (wr) begin
        case (cmd_addr)
          ADDR_CTRL: begin
            mode_q     <= cmd_data[CTRL_MODE];
            wave_sel_q <= cmd_data[CTRL_WSEL_LO +: 2];
          end
          ADDR_STEP_DIV: step_div_q <= cmd_data[DIV_W-1:0];
          ADDR_BURST_N:  burst_n_q  <= cmd_data[BURST_W-1:0];
          default:       phase_q    <= cmd_data[7:0];
        endcase
      end

      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= (state_q == ST_DONE);
          if (start_cmd && !stop_cmd) begin
            state_q <= ST_ARM;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_ARM: begin
          rom_addr_q <= phase_q;
          periods_q  <= '0;
          state_q    <= ST_RUN;
          busy_q     <= 1'b1;
        end
        ST_RUN: begin
          // stop beats both a restart and a coincident step boundary
          if (stop_cmd) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (start_cmd) begin
            state_q <= ST_ARM;
          end else if (tick) begin
            rom_addr_q <= rom_addr_inc;
            step_q     <= 1'b1;
            if (rom_addr_inc == phase_q) begin
              sync_q    <= 1'b1;
              periods_q <= periods_inc;
              if (mode_q && (periods_inc >= burst_eff)) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr   = rom_addr_q;
  assign step_pulse = step_q;
  assign sync_pulse = sync_q;
  assign wave_sel   = wave_sel_q;
  assign busy       = busy_q;
  assign done_pulse = done_q;
endmodule

// File: tb/tb_wave_seq_ctrl.sv
// Self-checking bench for wave_seq_ctrl: step/sync/done schedules predicted from register settings.
module tb_wave_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_addr = 2'd0;
  logic [31:0] cmd_data = 32'd0;
  logic [7:0]  rom_addr;
  logic        step_pulse, sync_pulse, busy, done_pulse;
  logic [1:0]  wave_sel;

  wave_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rom_addr(rom_addr),
    .step_pulse(step_pulse), .sync_pulse(sync_pulse), .wave_sel(wave_sel),
    .busy(busy), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int         cyc;
    logic [7:0] addr;
    logic       sync;
  } step_t;

  step_t step_log[$];
  int    done_log[$];
  logic  done_busy[$];
  int    orphan_sync = 0;
  step_t ev;

  always @(negedge clk) begin
    if (rst_n) begin
      if (step_pulse) begin
        ev.cyc  = cyc;
        ev.addr = rom_addr;
        ev.sync = sync_pulse;
        step_log.push_back(ev);
      end else if (sync_pulse) begin
        orphan_sync++;
      end
      if (done_pulse) begin
        done_log.push_back(cyc);
        done_busy.push_back(busy);
      end
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    step_log.delete();
    done_log.delete();
    done_busy.delete();
    orphan_sync = 0;
  endtask

  // Called at posedge+1; returns the cycle index of the first interval after acceptance.
  task automatic write_reg(input logic [1:0] a, input logic [31:0] d, output int acc);
    int guard;
    guard = 0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    while (!cmd_ready && guard < 50) begin
      tick1();
      guard++;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick1();
    rst_n = 1'b1;
    tick1();
    n_total++;
    if ({rom_addr, step_pulse, sync_pulse, wave_sel, busy, done_pulse} !== 14'd0)
      $display("FAIL reset_outputs: got %h required 0",
               {rom_addr, step_pulse, sync_pulse, wave_sel, busy, done_pulse});
    else n_pass++;
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", cmd_ready);
    else n_pass++;
  endtask

  task automatic test_continuous();
    int a, d, s, exp_n, g;
    logic [1:0] ws;
    logic [7:0] ea;
    ws = 2'($urandom_range(0, 3));
    clear_logs();
    write_reg(2'd1, 32'd4, d);
    write_reg(2'd3, 32'd0, d);
    write_reg(2'd0, {26'd0, ws, 4'b0001}, a);
    n_total++;
    if (busy !== 1'b1 || wave_sel !== ws)
      $display("FAIL cont_arm: busy=%b wave_sel=%0d required busy=1 wave_sel=%0d", busy, wave_sel, ws);
    else n_pass++;
    g = 0;
    while (step_log.size() < 257 && g < 1200) begin tick1(); g++; end
    n_total++;
    if (step_log.size() < 257) $display("FAIL cont_timeout: got %0d steps required 257", step_log.size());
    else n_pass++;
    write_reg(2'd0, 32'd2, s);
    repeat (3) tick1();
    exp_n = (s - a - 2) / 4;
    n_total++;
    if (step_log.size() !== exp_n) $display("FAIL cont_count: got %0d required %0d", step_log.size(), exp_n);
    else n_pass++;
    for (int k = 1; k <= step_log.size(); k++) begin
      ea = 8'(k);
      n_total++;
      if (step_log[k-1].cyc !== a + 1 + 4*k || step_log[k-1].addr !== ea ||
          step_log[k-1].sync !== ((k % 256) == 0)) begin
        $display("FAIL cont_step%0d: cyc=%0d addr=%h sync=%b required cyc=%0d addr=%h sync=%b",
                 k, step_log[k-1].cyc, step_log[k-1].addr, step_log[k-1].sync,
                 a + 1 + 4*k, ea, ((k % 256) == 0));
        break;
      end else n_pass++;
    end
    n_total++;
    if (busy !== 1'b0 || rom_addr !== 8'(exp_n))
      $display("FAIL cont_stop: busy=%b rom_addr=%h required 0 %h", busy, rom_addr, 8'(exp_n));
    else n_pass++;
  endtask

  task automatic run_burst(input int div, input int bn, input logic [7:0] ph);
    int a, d, de, be, total, g;
    logic [7:0] ea;
    de = (div == 0) ? 1 : div;
    be = (bn == 0) ? 1 : bn;
    total = 256 * be;
    clear_logs();
    write_reg(2'd1, 32'(div), d);
    write_reg(2'd2, 32'(bn), d);
    write_reg(2'd3, {24'd0, ph}, d);
    write_reg(2'd0, 32'h5, a);
    g = 0;
    while (done_log.size() == 0 && g < total * de + 50) begin tick1(); g++; end
    repeat (4) tick1();
    n_total++;
    if (done_log.size() !== 1) $display("FAIL burst_done_count div=%0d n=%0d: got %0d required 1", div, bn, done_log.size());
    else n_pass++;
    n_total++;
    if (step_log.size() !== total) $display("FAIL burst_steps div=%0d n=%0d: got %0d required %0d", div, bn, step_log.size(), total);
    else n_pass++;
    for (int k = 1; k <= step_log.size(); k++) begin
      ea = 8'(ph + 8'(k));
      n_total++;
      if (step_log[k-1].cyc !== a + 1 + k*de || step_log[k-1].addr !== ea ||
          step_log[k-1].sync !== ((k % 256) == 0)) begin
        $display("FAIL burst_step%0d div=%0d: cyc=%0d addr=%h sync=%b required cyc=%0d addr=%h sync=%b",
                 k, div, step_log[k-1].cyc, step_log[k-1].addr, step_log[k-1].sync,
                 a + 1 + k*de, ea, ((k % 256) == 0));
        break;
      end else n_pass++;
    end
    if (done_log.size() > 0) begin
      n_total++;
      if (done_log[0] !== a + 2 + total*de || done_busy[0] !== 1'b0)
        $display("FAIL burst_done_time: cyc=%0d busy=%b required cyc=%0d busy=0",
                 done_log[0], done_busy[0], a + 2 + total*de);
      else n_pass++;
    end
    n_total++;
    if (busy !== 1'b0 || rom_addr !== ph || orphan_sync !== 0)
      $display("FAIL burst_end: busy=%b rom_addr=%h orphan_sync=%0d required 0 %h 0", busy, rom_addr, orphan_sync, ph);
    else n_pass++;
  endtask

  task automatic test_burst();
    run_burst(1, 2, 8'h80);
  endtask

  task automatic test_zero_regs();
    run_burst(0, 0, 8'($urandom));
  endtask

  task automatic test_random_bursts();
    for (int i = 0; i < 3; i++)
      run_burst($urandom_range(1, 4), $urandom_range(1, 2), 8'($urandom));
  endtask

  task automatic test_stop_boundary();
    int a, d, r0, m, g;
    logic [7:0] ph, ea;
    ph = 8'($urandom);
    clear_logs();
    write_reg(2'd1, 32'd3, d);
    write_reg(2'd3, {24'd0, ph}, d);
    write_reg(2'd0, 32'd1, a);
    r0 = a + 1;
    repeat ($urandom_range(20, 40)) tick1();
    g = 0;
    while (((cyc - r0) % 3) != 2 && g < 5) begin tick1(); g++; end
    m  = (cyc - r0) / 3;
    ea = 8'(ph + 8'(m));
    write_reg(2'd0, 32'd2, d);
    n_total++;
    if (busy !== 1'b0 || step_pulse !== 1'b0 || rom_addr !== ea)
      $display("FAIL stop_boundary: busy=%b step=%b rom_addr=%h required 0 0 %h", busy, step_pulse, rom_addr, ea);
    else n_pass++;
    repeat (5) tick1();
    n_total++;
    if (step_log.size() !== m || rom_addr !== ea)
      $display("FAIL stop_hold: steps=%0d rom_addr=%h required %0d %h", step_log.size(), rom_addr, m, ea);
    else n_pass++;
  endtask

  task automatic test_div_change();
    int a, d, r0, m, g, ec;
    logic [7:0] ph, ea;
    ph = 8'($urandom);
    clear_logs();
    write_reg(2'd1, 32'd8, d);
    write_reg(2'd3, {24'd0, ph}, d);
    write_reg(2'd0, 32'd1, a);
    r0 = a + 1;
    repeat ($urandom_range(30, 50)) tick1();
    g = 0;
    while (((cyc - r0) % 8) != 3 && g < 10) begin tick1(); g++; end
    m = (cyc - r0) / 8;
    write_reg(2'd1, 32'd2, d);
    g = 0;
    while (step_log.size() < m + 13 && g < 200) begin tick1(); g++; end
    n_total++;
    if (step_log.size() < m + 13) $display("FAIL div_timeout: got %0d steps required %0d", step_log.size(), m + 13);
    else n_pass++;
    write_reg(2'd0, 32'd2, d);
    repeat (3) tick1();
    for (int k = 1; k <= step_log.size(); k++) begin
      ec = (k <= m + 1) ? r0 + 8*k : r0 + 8*(m + 1) + 2*(k - m - 1);
      ea = 8'(ph + 8'(k));
      n_total++;
      if (step_log[k-1].cyc !== ec || step_log[k-1].addr !== ea) begin
        $display("FAIL div_step%0d: cyc=%0d addr=%h required cyc=%0d addr=%h",
                 k, step_log[k-1].cyc, step_log[k-1].addr, ec, ea);
        break;
      end else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    int a, d, g;
    clear_logs();
    write_reg(2'd1, 32'd1, d);
    write_reg(2'd3, 32'd0, d);
    write_reg(2'd0, 32'h31, a);
    g = 0;
    while (rom_addr !== 8'h37 && g < 400) begin tick1(); g++; end
    n_total++;
    if (rom_addr !== 8'h37) $display("FAIL areset_reach: rom_addr=%h required 37", rom_addr);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    clear_logs();
    n_total++;
    if ({rom_addr, step_pulse, sync_pulse, wave_sel, busy, done_pulse} !== 14'd0)
      $display("FAIL areset_outputs: got %h required 0",
               {rom_addr, step_pulse, sync_pulse, wave_sel, busy, done_pulse});
    else n_pass++;
    repeat (2) tick1();
    #2 rst_n = 1'b1;
    repeat (20) tick1();
    n_total++;
    if (step_log.size() !== 0 || done_log.size() !== 0 || busy !== 1'b0 || rom_addr !== 8'h00)
      $display("FAIL areset_release: steps=%0d dones=%0d busy=%b rom_addr=%h required 0 0 0 00",
               step_log.size(), done_log.size(), busy, rom_addr);
    else n_pass++;
    write_reg(2'd0, 32'd1, a);
    repeat (300) tick1();
    n_total++;
    if (busy !== 1'b1 || step_log.size() !== 0 || rom_addr !== 8'h00)
      $display("FAIL areset_default_div: busy=%b steps=%0d rom_addr=%h required 1 0 00",
               busy, step_log.size(), rom_addr);
    else n_pass++;
    write_reg(2'd0, 32'd2, d);
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_burst();
    test_zero_regs();
    test_stop_boundary();
    test_div_change();
    test_random_bursts();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
